// File: rtl/codedlock_param.sv
// Clocked code lock: stored CODE_W-bit code, timed open/error windows,
// failed-attempt lockout and a verified two-step code change with timeout.
module codedlock_param #(
    parameter int                CODE_W         = 4,
    parameter logic [CODE_W-1:0] INIT_CODE      = {CODE_W{1'b1}},
    parameter int                MAX_FAIL       = 3,
    parameter int                OPEN_CYCLES    = 500,
    parameter int                ERR_CYCLES     = 200,
    parameter int                LOCK_CYCLES    = 1000,
    parameter int                TIMEOUT_CYCLES = 2000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [CODE_W-1:0]               code_in,
    input  logic                            enter,
    input  logic                            chg_req,
    output logic                            open,
    output logic                            alarm,
    output logic                            locked_out,
    output logic                            chg_mode,
    output logic                            chg_done,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt,
    output logic                            led_open_n,
    output logic                            led_alarm_n
);

    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int T_A    = (OPEN_CYCLES > ERR_CYCLES) ? OPEN_CYCLES : ERR_CYCLES;
    localparam int T_B    = (LOCK_CYCLES > TIMEOUT_CYCLES) ? LOCK_CYCLES : TIMEOUT_CYCLES;
    localparam int T_MAX  = (T_A > T_B) ? T_A : T_B;
    localparam int TMR_W  = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [TMR_W-1:0]  OPEN_LD = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0]  ERR_LD  = TMR_W'(ERR_CYCLES - 1);
    localparam logic [TMR_W-1:0]  LOCK_LD = TMR_W'(LOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TO_LD   = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FAIL_W-1:0] FAIL_LIM = FAIL_W'(MAX_FAIL);

    typedef enum logic [2:0] {
        S_IDLE, S_OPEN, S_ERR, S_LOCKOUT, S_CHG_NEW, S_CHG_CONF
    } state_t;

    state_t             state, state_n;
    logic [CODE_W-1:0]  stored, stored_n;
    logic [CODE_W-1:0]  new_reg, new_n;
    logic [TMR_W-1:0]   timer, timer_n;
    logic [FAIL_W-1:0]  fail_n, fail_inc;
    logic               done_n;
    logic               expired;

    always_comb begin
        state_n  = state;
        stored_n = stored;
        new_n    = new_reg;
        timer_n  = timer;
        fail_n   = fail_cnt;
        done_n   = 1'b0;
        fail_inc = fail_cnt + 1'b1;
        expired  = (timer == '0);
        case (state)
            S_IDLE: begin
                // A simultaneous enter and chg_req is treated as enter alone.
                if (enter || chg_req) begin
                    if (code_in == stored) begin
                        fail_n = '0;
                        if (enter) begin
                            state_n = S_OPEN;
                            timer_n = OPEN_LD;
                        end else begin
                            state_n = S_CHG_NEW;
                            timer_n = TO_LD;
                        end
                    end else begin
                        fail_n = fail_inc;
                        if (fail_inc == FAIL_LIM) begin
                            state_n = S_LOCKOUT;
                            timer_n = LOCK_LD;
                        end else begin
                            state_n = S_ERR;
                            timer_n = ERR_LD;
                        end
                    end
                end
            end
            S_OPEN, S_ERR: begin
                if (expired) state_n = S_IDLE;
                else         timer_n = timer - 1'b1;
            end
            S_LOCKOUT: begin
                if (expired) begin
                    state_n = S_IDLE;
                    fail_n  = '0;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            S_CHG_NEW: begin
                // Abort (explicit or timeout) takes priority over enter.
                if (chg_req || expired) begin
                    state_n = S_IDLE;
                end else if (enter) begin
                    new_n   = code_in;
                    state_n = S_CHG_CONF;
                    timer_n = TO_LD;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            S_CHG_CONF: begin
                if (chg_req || expired) begin
                    state_n = S_IDLE;
                end else if (enter) begin
                    if (code_in == new_reg) begin
                        stored_n = new_reg;
                        done_n   = 1'b1;
                        state_n  = S_IDLE;
                    end else begin
                        state_n = S_ERR;
                        timer_n = ERR_LD;
                    end
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next-state decode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            stored      <= INIT_CODE;
            new_reg     <= '0;
            timer       <= '0;
            fail_cnt    <= '0;
            open        <= 1'b0;
            alarm       <= 1'b0;
            locked_out  <= 1'b0;
            chg_mode    <= 1'b0;
            chg_done    <= 1'b0;
            led_open_n  <= 1'b1;
            led_alarm_n <= 1'b1;
        end else begin
            state       <= state_n;
            stored      <= stored_n;
            new_reg     <= new_n;
            timer       <= timer_n;
            fail_cnt    <= fail_n;
            open        <= (state_n == S_OPEN);
            alarm       <= (state_n == S_ERR) || (state_n == S_LOCKOUT);
            locked_out  <= (state_n == S_LOCKOUT);
            chg_mode    <= (state_n == S_CHG_NEW) || (state_n == S_CHG_CONF);
            chg_done    <= done_n;
            led_open_n  <= !(state_n == S_OPEN);
            led_alarm_n <= !((state_n == S_ERR) || (state_n == S_LOCKOUT));
        end
    end

endmodule

// File: tb/tb_codedlock_param.sv
// Bench for codedlock_param: behavioural reference model feeds an expected-output
// queue each driven cycle; DUT outputs are popped and compared after each edge.
module tb_codedlock_param;

    localparam int MAXF = 3;
    localparam int N_OPEN = 4, N_ERR = 2, N_LOCK = 8, N_TO = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] code_in = 4'h0;
    logic       enter = 1'b0;
    logic       chg_req = 1'b0;
    logic       open, alarm, locked_out, chg_mode, chg_done;
    logic [1:0] fail_cnt;
    logic       led_open_n, led_alarm_n;

    codedlock_param #(
        .CODE_W(4), .INIT_CODE(4'hF), .MAX_FAIL(MAXF),
        .OPEN_CYCLES(N_OPEN), .ERR_CYCLES(N_ERR),
        .LOCK_CYCLES(N_LOCK), .TIMEOUT_CYCLES(N_TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .code_in(code_in), .enter(enter),
        .chg_req(chg_req), .open(open), .alarm(alarm), .locked_out(locked_out),
        .chg_mode(chg_mode), .chg_done(chg_done), .fail_cnt(fail_cnt),
        .led_open_n(led_open_n), .led_alarm_n(led_alarm_n)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: rem counts cycles still to spend in the current state.
    typedef enum int {M_IDLE, M_OPEN, M_ERR, M_LOCK, M_NEW, M_CONF} mstate_t;
    mstate_t    m_st = M_IDLE;
    int         m_rem = 0;
    int         m_fail = 0;
    logic [3:0] m_stored = 4'hF;
    logic [3:0] m_new = 4'h0;
    logic       m_done = 1'b0;

    logic [8:0] sb_q[$];
    int cnt_open, cnt_lock, cnt_chg, cnt_done;

    task automatic model_fail();
        m_fail++;
        if (m_fail == MAXF) begin m_st = M_LOCK; m_rem = N_LOCK; end
        else                begin m_st = M_ERR;  m_rem = N_ERR;  end
    endtask

    task automatic model_step(input logic r, input logic en, input logic chg, input logic [3:0] c);
        m_done = 1'b0;
        if (!r) begin
            m_st = M_IDLE; m_rem = 0; m_fail = 0; m_stored = 4'hF; m_new = 4'h0;
        end else begin
            case (m_st)
                M_IDLE: begin
                    if (en) begin
                        if (c == m_stored) begin m_st = M_OPEN; m_rem = N_OPEN; m_fail = 0; end
                        else model_fail();
                    end else if (chg) begin
                        if (c == m_stored) begin m_st = M_NEW; m_rem = N_TO; m_fail = 0; end
                        else model_fail();
                    end
                end
                M_OPEN, M_ERR: begin
                    m_rem--;
                    if (m_rem == 0) m_st = M_IDLE;
                end
                M_LOCK: begin
                    m_rem--;
                    if (m_rem == 0) begin m_st = M_IDLE; m_fail = 0; end
                end
                M_NEW, M_CONF: begin
                    if (chg || m_rem == 1) m_st = M_IDLE;
                    else if (en && m_st == M_NEW) begin m_new = c; m_st = M_CONF; m_rem = N_TO; end
                    else if (en) begin
                        if (c == m_new) begin m_stored = m_new; m_done = 1'b1; m_st = M_IDLE; end
                        else begin m_st = M_ERR; m_rem = N_ERR; end
                    end else m_rem--;
                end
                default: m_st = M_IDLE;
            endcase
        end
    endtask

    function automatic logic [8:0] model_out();
        logic o, a;
        o = (m_st == M_OPEN);
        a = (m_st == M_ERR) || (m_st == M_LOCK);
        return {o, a, (m_st == M_LOCK), (m_st == M_NEW || m_st == M_CONF),
                m_done, 2'(m_fail), ~o, ~a};
    endfunction

    task automatic cyc(input logic r, input logic en, input logic chg, input logic [3:0] c);
        logic [8:0] exp;
        @(negedge clk);
        rst_n = r; enter = en; chg_req = chg; code_in = c;
        model_step(r, en, chg, c);
        sb_q.push_back(model_out());
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            exp = sb_q.pop_front();
            check("outputs", {23'd0, open, alarm, locked_out, chg_mode, chg_done,
                              fail_cnt, led_open_n, led_alarm_n}, {23'd0, exp});
        end
        cnt_open += int'(open);
        cnt_lock += int'(locked_out);
        cnt_chg  += int'(chg_mode);
        cnt_done += int'(chg_done);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic clr_counts();
        cnt_open = 0; cnt_lock = 0; cnt_chg = 0; cnt_done = 0;
    endtask

    initial begin
        clr_counts();
        // Reset state
        cyc(1'b0, 1'b0, 1'b0, 4'h0);
        cyc(1'b0, 1'b1, 1'b1, 4'hF);
        check("reset_leds", {30'd0, led_open_n, led_alarm_n}, 32'd3);
        check("reset_fail", {30'd0, fail_cnt}, 32'd0);

        // 1: correct code opens for exactly N_OPEN cycles
        clr_counts();
        cyc(1'b1, 1'b1, 1'b0, 4'hF);
        check("t1_open_first", {31'd0, open}, 32'd1);
        check("t1_led_open_n", {31'd0, led_open_n}, 32'd0);
        idle(6);
        check("t1_open_len", cnt_open, N_OPEN);

        // 2: three wrong codes lead to lockout; enter during lockout ignored
        clr_counts();
        for (int k = 1; k <= 3; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 4'h3);
            if (k < 3) begin
                check("t2_fail_cnt", {30'd0, fail_cnt}, k);
                idle(3);
            end
        end
        cyc(1'b1, 1'b1, 1'b0, 4'hF);
        idle(9);
        check("t2_lock_len", cnt_lock, N_LOCK);
        check("t2_no_open", cnt_open, 0);
        check("t2_fail_clr", {30'd0, fail_cnt}, 32'd0);

        // 3: change to A, old code rejected, new code accepted, restore F
        clr_counts();
        cyc(1'b1, 1'b0, 1'b1, 4'hF);
        cyc(1'b1, 1'b1, 1'b0, 4'hA);
        cyc(1'b1, 1'b1, 1'b0, 4'hA);
        check("t3_chg_done", {31'd0, chg_done}, 32'd1);
        idle(1);
        cyc(1'b1, 1'b1, 1'b0, 4'hF);
        check("t3_old_rejected", {31'd0, alarm}, 32'd1);
        idle(3);
        cyc(1'b1, 1'b1, 1'b0, 4'hA);
        check("t3_new_opens", {31'd0, open}, 32'd1);
        idle(5);
        cyc(1'b1, 1'b0, 1'b1, 4'hA);
        cyc(1'b1, 1'b1, 1'b0, 4'hF);
        cyc(1'b1, 1'b1, 1'b0, 4'hF);
        idle(1);
        check("t3_done_pulses", cnt_done, 2);

        // 4: mismatched confirm gives ERR, stored code untouched
        cyc(1'b1, 1'b0, 1'b1, 4'hF);
        cyc(1'b1, 1'b1, 1'b0, 4'hA);
        cyc(1'b1, 1'b1, 1'b0, 4'h5);
        check("t4_err", {31'd0, alarm}, 32'd1);
        idle(3);
        cyc(1'b1, 1'b1, 1'b0, 4'hF);
        check("t4_code_kept", {31'd0, open}, 32'd1);
        idle(5);

        // 5: inactivity timeout, then explicit abort from CHG_CONF
        clr_counts();
        cyc(1'b1, 1'b0, 1'b1, 4'hF);
        idle(8);
        check("t5_timeout_len", cnt_chg, N_TO);
        cyc(1'b1, 1'b0, 1'b1, 4'hF);
        cyc(1'b1, 1'b1, 1'b0, 4'hA);
        cyc(1'b1, 1'b0, 1'b1, 4'h0);
        check("t5_abort", {30'd0, chg_mode, alarm}, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 4'hF);
        check("t5_code_kept", {31'd0, open}, 32'd1);
        idle(5);

        // 6: reset in CHG_CONF after committing A restores INIT_CODE
        cyc(1'b1, 1'b0, 1'b1, 4'hF);
        cyc(1'b1, 1'b1, 1'b0, 4'hA);
        cyc(1'b1, 1'b1, 1'b0, 4'hA);
        idle(1);
        cyc(1'b1, 1'b0, 1'b1, 4'hA);
        cyc(1'b1, 1'b1, 1'b0, 4'h3);
        check("t6_in_conf", {31'd0, chg_mode}, 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 4'h0);
        check("t6_reset_out", {23'd0, open, alarm, locked_out, chg_mode, chg_done,
                               fail_cnt, led_open_n, led_alarm_n}, 32'h003);
        cyc(1'b1, 1'b1, 1'b0, 4'hF);
        check("t6_init_code", {31'd0, open}, 32'd1);
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/codedlock_param.md
Name: codedlock_param

Overview:
Clocked, parametrised successor to the team's combinational 4-switch code lock. It adds:
- CODE_W-bit codes with a registered stored code.
- Strobed entry with timed open and error windows.
- A failed-attempt counter with timed lockout.
- A verified two-step code-change sequence (old code, new code, confirm) with inactivity timeout.
It sits between debounced switch/button synchronisers and the board LEDs.

Parameters:
CODE_W, 4, code width in bits (>=1)
INIT_CODE, {CODE_W{1'b1}}, stored code after reset
MAX_FAIL, 3, consecutive wrong attempts that trigger lockout (>=1)
OPEN_CYCLES, 500, cycles OPEN state lasts (>=1)
ERR_CYCLES, 200, cycles ERR state lasts (>=1)
LOCK_CYCLES, 1000, cycles LOCKOUT state lasts (>=1)
TIMEOUT_CYCLES, 2000, idle cycles allowed in CHG_NEW/CHG_CONF before abort (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
code_in  in  CODE_W  code switches, already synchronised and debounced
enter  in  1  one-cycle strobe: submit code_in
chg_req  in  1  one-cycle strobe: request code change (code_in = old code)
open  out  1  lock released
alarm  out  1  error or lockout indication
locked_out  out  1  high while in LOCKOUT
chg_mode  out  1  high in CHG_NEW or CHG_CONF
chg_done  out  1  one-cycle pulse when a new code is committed
fail_cnt  out  $clog2(MAX_FAIL+1)  current consecutive-failure count
led_open_n  out  1  ~open, active-low LED
led_alarm_n  out  1  ~alarm, active-low LED

Behaviour:
- Single clock domain. Synchronous active-low reset.
- Reset forces: state=IDLE, stored code=INIT_CODE, new_reg=0, timer=0, fail_cnt=0, all status outputs 0, LED outputs 1.
- Reset mid-change discards any pending new code.
- All status outputs are registered. A strobe sampled at edge k is reflected in the outputs after edge k, i.e. 1-cycle latency.
- States: IDLE, OPEN, ERR, LOCKOUT, CHG_NEW, CHG_CONF.
- Output decode: open=1 only in OPEN. alarm=1 in ERR and LOCKOUT. locked_out=1 in LOCKOUT. chg_mode=1 in CHG_NEW and CHG_CONF.
- Timed states (OPEN, ERR, LOCKOUT) last exactly their parameter count in cycles. The down-counter loads N-1 on entry and exits when it reads 0.
- IDLE, enter with code_in==stored: go to OPEN; fail_cnt<=0.
- IDLE, enter with mismatch: fail_cnt+1.
  - If the result ==MAX_FAIL: go to LOCKOUT.
  - Otherwise: go to ERR.
- IDLE, chg_req (no enter) with code_in==stored: go to CHG_NEW; fail_cnt<=0; timeout counter loaded.
- IDLE, chg_req with mismatch: counted as a failure, identical to a wrong enter.
- IDLE, enter and chg_req in the same cycle: enter wins; chg_req is ignored.
- CHG_NEW, enter: new_reg<=code_in; go to CHG_CONF; timeout reloaded.
- CHG_CONF, enter with code_in==new_reg: stored<=new_reg; chg_done pulses 1 cycle; go to IDLE.
- CHG_CONF, enter with mismatch: stored code unchanged; go to ERR; fail_cnt unchanged.
- CHG_NEW/CHG_CONF, chg_req strobe or TIMEOUT_CYCLES cycles without enter: abort to IDLE, stored code unchanged, no alarm. Abort wins over a simultaneous enter.
- OPEN and ERR: enter and chg_req ignored; return to IDLE on expiry.
- LOCKOUT: all inputs ignored; on expiry fail_cnt<=0 and go to IDLE.
- A successful open clears fail_cnt. ERR expiry does not clear it.
- The new stored code is used starting with the first compare after the chg_done cycle.
- Counter widths: $clog2 of the respective parameter, minimum 1 bit. fail_cnt never exceeds MAX_FAIL.

Test Plan:
(Bench parameters: CODE_W=4, INIT_CODE=4'hF, MAX_FAIL=3, OPEN_CYCLES=4, ERR_CYCLES=2, LOCK_CYCLES=8, TIMEOUT_CYCLES=6.)
1. Reset, then enter with code 4'hF -> open=1 for exactly 4 cycles starting the cycle after the strobe, led_open_n=0, then IDLE.
2. Enter 4'h3 three times, each after ERR expires -> fail_cnt 1, 2, then locked_out=alarm=1 for 8 cycles. An enter of 4'hF during lockout is ignored. fail_cnt=0 afterwards.
3. chg_req with 4'hF, enter 4'hA, enter 4'hA -> chg_done pulse. Enter 4'hF then gives ERR; enter 4'hA then gives OPEN.
4. chg_req with 4'hF, enter 4'hA, enter 4'h5 -> ERR for 2 cycles; stored code still 4'hF; fail_cnt unchanged.
5. chg_req with 4'hF, then no strobes for 6 cycles -> chg_mode drops, IDLE, code still 4'hF. Repeat with a chg_req abort from CHG_CONF -> same result.
6. Assert rst_n=0 for one cycle while in CHG_CONF after committing 4'hA -> stored code returns to 4'hF; all outputs reset values.
